// File: rtl/console_pkg.sv
// Shared types and constants for the text console writer.
package console_pkg;

  typedef enum logic [2:0] {CLR_ALL, IDLE, PUT, SCROLL, CLR_ROW} state_t;

  localparam logic [6:0] CLEAR_CHAR         = 7'h20;
  localparam logic [2:0] DEFAULT_TEXT_COLOR = 3'b010;
  localparam logic [9:0] BLANK_CELL         = {DEFAULT_TEXT_COLOR, CLEAR_CHAR};

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  function automatic logic [4:0] cell_index(input logic [1:0] row, input logic [3:0] col,
                                            input int cols);
    return 5'(int'(row) * cols + int'(col));
  endfunction

endpackage

// File: rtl/console_writer.sv
// Byte-stream console writer: places characters into a text buffer, handles control codes.
// Define CONSOLE_WRITER_SCROLL_EN to scroll at end of screen instead of wrapping to row 0.
//
// state   | meaning
// CLR_ALL | blank every cell, addresses ascending
// IDLE    | accept one byte
// PUT     | write latched character at latched cell
// SCROLL  | copy rows 1..N-1 up by one row
// CLR_ROW | blank the target row
import console_pkg::*;

module console_writer #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [2:0] in_color,
  output logic       buf_we,
  output logic [4:0] buf_addr,
  output logic [9:0] buf_wdata,
  output logic [4:0] buf_raddr,
  input  logic [9:0] buf_rdata,
  output logic [1:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic       busy
);

  localparam logic [1:0] ROW_LAST    = 2'(NUM_ROWS - 1);
  localparam logic [3:0] COL_LAST    = 4'(NUM_COLS - 1);
  localparam logic [4:0] CELL_LAST   = 5'(NUM_ROWS * NUM_COLS - 1);
  localparam logic [4:0] ROWCNT_LAST = 5'(NUM_COLS - 1);
`ifdef CONSOLE_WRITER_SCROLL_EN
  localparam logic [4:0] SCROLL_LAST = 5'((NUM_ROWS - 1) * NUM_COLS - 1);
  localparam logic [4:0] COLS5       = 5'(NUM_COLS);
  localparam state_t     EOS_STATE   = SCROLL;
`else
  localparam state_t     EOS_STATE   = CLR_ROW;
`endif

  state_t     state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic [1:0] row, row_nxt;
  logic [3:0] col, col_nxt;
  logic [9:0] lat_cell, lat_cell_nxt;
  logic [4:0] lat_addr, lat_addr_nxt;
  logic       wrap, wrap_nxt;
  logic [1:0] clr_row, clr_row_nxt;
  logic       nl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLR_ALL;
      cnt      <= '0;
      row      <= '0;
      col      <= '0;
      lat_cell <= BLANK_CELL;
      lat_addr <= '0;
      wrap     <= 1'b0;
      clr_row  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      row      <= row_nxt;
      col      <= col_nxt;
      lat_cell <= lat_cell_nxt;
      lat_addr <= lat_addr_nxt;
      wrap     <= wrap_nxt;
      clr_row  <= clr_row_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    row_nxt      = row;
    col_nxt      = col;
    lat_cell_nxt = lat_cell;
    lat_addr_nxt = lat_addr;
    wrap_nxt     = wrap;
    clr_row_nxt  = clr_row;
    nl           = 1'b0;
    in_ready     = 1'b0;
    buf_we       = 1'b0;
    buf_addr     = '0;
    buf_wdata    = BLANK_CELL;
    buf_raddr    = '0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!in_data[7] && in_data[6:0] >= 7'h20 && in_data[6:0] <= 7'h7E) begin
            lat_cell_nxt = {in_color, in_data[6:0]};
            lat_addr_nxt = cell_index(row, col, NUM_COLS);
            state_nxt    = PUT;
            if (col == COL_LAST) begin
              col_nxt = '0;
              nl      = 1'b1;
            end else begin
              col_nxt = col + 4'd1;
            end
          end else begin
            case (in_data)
              CH_LF: begin
                col_nxt = '0;
                nl      = 1'b1;
              end
              CH_CR: col_nxt = '0;
              CH_BS: if (col != 4'd0) col_nxt = col - 4'd1;
              CH_FF: begin
                row_nxt   = '0;
                col_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      PUT: begin
        buf_we    = 1'b1;
        buf_addr  = lat_addr;
        buf_wdata = lat_cell;
        cnt_nxt   = '0;
        wrap_nxt  = 1'b0;
        state_nxt = wrap ? EOS_STATE : IDLE;
      end
`ifdef CONSOLE_WRITER_SCROLL_EN
      SCROLL: begin
        buf_raddr = cnt + COLS5;
        buf_we    = 1'b1;
        buf_addr  = cnt;
        buf_wdata = buf_rdata;
        if (cnt == SCROLL_LAST) begin
          cnt_nxt   = '0;
          state_nxt = CLR_ROW;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
`endif
      CLR_ROW: begin
        buf_we   = 1'b1;
        buf_addr = cell_index(clr_row, cnt[3:0], NUM_COLS);
        if (cnt == ROWCNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      CLR_ALL: begin
        buf_we   = 1'b1;
        buf_addr = cnt;
        if (cnt == CELL_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = CLR_ALL;
      end
    endcase

    // A wrapping printable defers the end-of-screen work until after its PUT cycle.
    if (nl) begin
      if (row != ROW_LAST) begin
        row_nxt = row + 2'd1;
      end else begin
`ifdef CONSOLE_WRITER_SCROLL_EN
        clr_row_nxt = ROW_LAST;
`else
        row_nxt     = '0;
        clr_row_nxt = '0;
`endif
        cnt_nxt = '0;
        if (state_nxt == PUT) wrap_nxt = 1'b1;
        else state_nxt = EOS_STATE;
      end
    end
  end

`ifndef CONSOLE_WRITER_SCROLL_EN
  logic unused_rdata;
  assign unused_rdata = ^buf_rdata;
`endif

  assign cursor_row = row;
  assign cursor_col = col;
  assign busy       = (state != IDLE);

endmodule

// File: doc/console_writer.md
CONSOLE_WRITER -- requirements
Module: console_writer

Interface
REQ-001 Parameter NUM_ROWS, default 3: text buffer rows.
REQ-002 Parameter NUM_COLS, default 10: text buffer columns.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  character byte offered.
REQ-006 in_ready  output  1  byte accepted on clk edge when in_valid & in_ready.
REQ-007 in_data  input  8  character or control code.
REQ-008 in_color  input  3  {B,G,R} text colour for printable bytes.
REQ-009 buf_we  output  1  text buffer write strobe.
REQ-010 buf_addr  output  5  write cell index (row*NUM_COLS+col).
REQ-011 buf_wdata  output  10  {colour[2:0], char[6:0]}.
REQ-012 buf_raddr  output  5  read cell index; buf_rdata valid combinationally in same cycle.
REQ-013 buf_rdata  input  10  text buffer read data.
REQ-014 cursor_row  output  2  current cursor row.
REQ-015 cursor_col  output  4  current cursor column.
REQ-016 busy  output  1  high whenever state != IDLE.

Function
REQ-017 States: CLR_ALL, IDLE, PUT, SCROLL, CLR_ROW; in_ready = (state == IDLE).
REQ-018 buf_* outputs decoded combinationally from state/counter/latched registers; buf_we=0 in IDLE.
REQ-019 Printable (0x20..0x7E, in_data[7]=0): latch {in_color,in_data[6:0]} and cursor; next cycle PUT writes it at latched cell; cursor advances on acceptance edge.
REQ-020 Cursor advance: col+1; at col==NUM_COLS-1 -> col=0 plus newline action.
REQ-021 LF 0x0A: col=0 plus newline action; no write.
REQ-022 CR 0x0D: col=0; BS 0x08: col-1 if col>0, else unchanged; no erase, no write.
REQ-023 FF 0x0C: cursor (0,0), enter CLR_ALL.
REQ-024 All other codes accepted and ignored; state stays IDLE.
REQ-025 Newline action: row<NUM_ROWS-1 -> row+1, no extra cycles; row==NUM_ROWS-1 -> end-of-screen action (Configuration).
REQ-026 PUT lasts exactly 1 cycle, then IDLE, or SCROLL/CLR_ROW if PUT's char wrapped on last row.
REQ-027 SCROLL: counter i=0..(NUM_ROWS-1)*NUM_COLS-1, one per cycle: buf_raddr=i+NUM_COLS, buf_we=1, buf_addr=i, buf_wdata=buf_rdata; then CLR_ROW.
REQ-028 CLR_ROW: NUM_COLS cycles writing blank cell {DEFAULT_TEXT_COLOR,CLEAR_CHAR} to target row's cells, ascending addresses; then IDLE.
REQ-029 CLR_ALL: NUM_ROWS*NUM_COLS cycles writing blank cell to addresses 0..N-1 ascending; then IDLE.
REQ-030 Blank cell = 10'h120 (colour 3'b010, char 0x20).
REQ-031 Cursor outputs show post-update position from edge after acceptance; never exceed NUM_ROWS-1 / NUM_COLS-1.

Reset
REQ-032 rst_n low: state=CLR_ALL, counter=0, cursor (0,0); any scroll/clear in progress abandoned.
REQ-033 Reset values: in_ready=0, busy=1, buf_we=1 with buf_addr=0 once rst_n high; full clear runs before first IDLE.

Configuration
REQ-034 Macro CONSOLE_WRITER_SCROLL_EN defined: end-of-screen -> SCROLL then CLR_ROW of last row, cursor_row stays NUM_ROWS-1.
REQ-035 Macro undefined: end-of-screen -> cursor_row=0, CLR_ROW of row 0; SCROLL state and buf_raddr logic absent (buf_raddr tied 0).

Structure
REQ-036 Package console_pkg: state enum, CLEAR_CHAR (7'h20), DEFAULT_TEXT_COLOR (3'b010), control-code constants (BS, LF, FF, CR).
REQ-037 No sub-module; single module with one shared cell counter.

Verification
REQ-038 Reset release -> 30 consecutive writes addr 0..29 data 0x120, in_ready low exactly 30 cycles, then high.
REQ-039 'A' (0x41) colour 3'b100 at (0,0) -> next cycle buf_we, addr 0, wdata 0x241; cursor_col=1.
REQ-040 11 printables from (0,0) -> 11th written at addr 10; cursor (1,1).
REQ-041 Cursor row 2, LF, SCROLL_EN -> 20 copies (addr i <- raddr i+10) then clears addr 20..29, in_ready low 30 cycles; without macro -> clears addr 0..9, cursor (0,0).
REQ-042 BS at col 0 -> no change; CR at col 5 -> col 0; 0x0C -> 30 clears, cursor (0,0); 0x07 -> no write.
REQ-043 rst_n low during SCROLL cycle 7 -> cursor (0,0), full 30-cycle clear restarts from addr 0.
